// File: rtl/mema_load_ctrl.sv
// A-operand row buffer controller: registers host row writes into the buffer, then streams the tile.
// Optional MEMA_AUTO_START_EN: enter RUN automatically once all rows are loaded, without waiting for start.
module mema_load_ctrl #(
  parameter int BITS_AB    = 32,
  parameter int DIM        = 8,
  parameter int STREAM_LEN = 2*DIM-1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [$clog2(DIM)-1:0]    wr_row,
  input  logic signed [BITS_AB-1:0] wr_data [DIM],
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      start_err,
  output logic [DIM-1:0]            rows_loaded,
  output logic                      mem_wr,
  output logic [$clog2(DIM)-1:0]    mem_row,
  output logic signed [BITS_AB-1:0] mem_din [DIM],
  output logic                      mem_en,
  output logic                      mem_go
);

  localparam int CNT_W = $clog2(STREAM_LEN+1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STREAM_LEN-1);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic [DIM-1:0]   row_bit;
  logic [DIM-1:0]   mask_next;
  logic             go;
  logic             start_bad;

  assign wr_ready = (state == S_LOAD);

  always_comb begin
    accept          = wr_valid && wr_ready;
    row_bit         = '0;
    row_bit[wr_row] = accept;
    mask_next       = rows_loaded | row_bit;
`ifdef MEMA_AUTO_START_EN
    // Auto mode waits one cycle after the mask is visibly complete; start is ignored in LOAD.
    go        = &rows_loaded;
    start_bad = 1'b0;
`else
    // The mask includes a write accepted in the same cycle as start.
    go        = start && (&mask_next);
    start_bad = start && !(&mask_next);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_LOAD;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      start_err   <= 1'b0;
      rows_loaded <= '0;
      mem_wr      <= 1'b0;
      mem_row     <= '0;
      mem_en      <= 1'b0;
      mem_go      <= 1'b0;
      for (int i = 0; i < DIM; i++) mem_din[i] <= '0;
    end else begin
      // write stage: one-cycle registered forward of the accepted row
      mem_wr    <= accept;
      if (accept) begin
        mem_row <= wr_row;
        mem_din <= wr_data;
      end
      mem_go    <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
      case (state)
        S_LOAD: begin
          rows_loaded <= mask_next;
          start_err   <= start_bad;
          if (go) begin
            state  <= S_RUN;
            cnt    <= '0;
            busy   <= 1'b1;
            mem_en <= 1'b1;
            mem_go <= 1'b1;
          end
        end
        S_RUN: begin
          start_err <= start;
          if (cnt == CNT_LAST) begin
            state       <= S_DONE;
            cnt         <= '0;
            busy        <= 1'b0;
            mem_en      <= 1'b0;
            done        <= 1'b1;
            rows_loaded <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          start_err <= start;
          state     <= S_LOAD;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mema_load_ctrl.sv
// Directed bench for mema_load_ctrl: row loading, streaming, start rejection, RUN isolation, reset abort.
module tb_mema_load_ctrl;
  localparam int BITS_AB = 32;
  localparam int DIM     = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic wr_valid;
  logic wr_ready;
  logic [2:0] wr_row;
  logic signed [BITS_AB-1:0] wr_data [DIM];
  logic start;
  logic busy, done, start_err;
  logic [DIM-1:0] rows_loaded;
  logic mem_wr;
  logic [2:0] mem_row;
  logic signed [BITS_AB-1:0] mem_din [DIM];
  logic mem_en, mem_go;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mema_load_ctrl #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_data(wr_data), .start(start), .busy(busy),
    .done(done), .start_err(start_err), .rows_loaded(rows_loaded),
    .mem_wr(mem_wr), .mem_row(mem_row), .mem_din(mem_din),
    .mem_en(mem_en), .mem_go(mem_go)
  );

  task automatic set_row(input int r, input bit neg);
    for (int e = 0; e < DIM; e++) wr_data[e] = neg ? -(e+1) : r*8+e;
  endtask

  // Back-to-back writes of the rows selected by m; returns at the negedge after the last write.
  task automatic load_rows(input logic [7:0] m);
    for (int r = 0; r < DIM; r++) begin
      if (m[r]) begin
        wr_valid = 1'b1; wr_row = 3'(r); set_row(r, 1'b0);
        @(negedge clk);
        wr_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_valid = 1'b0; start = 1'b0; wr_row = '0; set_row(0, 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if ({wr_ready,busy,done,start_err,mem_wr,mem_en,mem_go} !== 7'b1000000) begin
      bad++; $display("FAIL reset_flags got=%b exp=1000000", {wr_ready,busy,done,start_err,mem_wr,mem_en,mem_go});
    end
    total++;
    if (rows_loaded !== 8'h00) begin bad++; $display("FAIL reset_mask got=%h exp=00", rows_loaded); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({wr_ready,busy,done,mem_wr,mem_en} !== 5'b10000) begin
      bad++; $display("FAIL post_reset_flags got=%b exp=10000", {wr_ready,busy,done,mem_wr,mem_en});
    end
  endtask

  task automatic test_load_rows();
    for (int r = 0; r < DIM; r++) begin
      wr_valid = 1'b1; wr_row = 3'(r); set_row(r, 1'b0);
      total++;
      if (wr_ready !== 1'b1) begin bad++; $display("FAIL load_ready row=%0d got=%b exp=1", r, wr_ready); end
      @(negedge clk);
      wr_valid = 1'b0;
      total++;
      if (mem_wr !== 1'b1 || mem_row !== 3'(r)) begin
        bad++; $display("FAIL load_strobe row=%0d got wr=%b row=%0d exp wr=1 row=%0d", r, mem_wr, mem_row, r);
      end
      for (int e = 0; e < DIM; e++) begin
        total++;
        if (mem_din[e] !== 32'(r*8+e)) begin
          bad++; $display("FAIL load_data row=%0d el=%0d got=%0d exp=%0d", r, e, mem_din[e], r*8+e);
        end
      end
      total++;
      if (rows_loaded[r] !== 1'b1) begin bad++; $display("FAIL load_mask row=%0d got=%h", r, rows_loaded); end
    end
    @(negedge clk);
    total++;
    if (mem_wr !== 1'b0 || rows_loaded !== 8'hFF) begin
      bad++; $display("FAIL load_final got wr=%b mask=%h exp wr=0 mask=ff", mem_wr, rows_loaded);
    end
    // overwrite row 2 with negative data; mask stays full
    wr_valid = 1'b1; wr_row = 3'd2; set_row(2, 1'b1);
    @(negedge clk);
    wr_valid = 1'b0;
    total++;
    if (mem_wr !== 1'b1 || mem_row !== 3'd2 || mem_din[0] !== -32'sd1 || mem_din[7] !== -32'sd8) begin
      bad++; $display("FAIL overwrite got wr=%b row=%0d d0=%0d d7=%0d exp 1 2 -1 -8", mem_wr, mem_row, mem_din[0], mem_din[7]);
    end
    total++;
    if (rows_loaded !== 8'hFF) begin bad++; $display("FAIL overwrite_mask got=%h exp=ff", rows_loaded); end
  endtask

  task automatic test_stream();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      total++;
      if (busy !== 1'b1 || mem_en !== 1'b1 || done !== 1'b0 || mem_go !== (i == 0)) begin
        bad++; $display("FAIL stream_cyc%0d got busy=%b en=%b go=%b done=%b", i, busy, mem_en, mem_go, done);
      end
      if (i == 0) begin
        total++;
        if (wr_ready !== 1'b0) begin bad++; $display("FAIL stream_ready got=%b exp=0", wr_ready); end
      end
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || mem_en !== 1'b0 || rows_loaded !== 8'h00 || wr_ready !== 1'b0) begin
      bad++; $display("FAIL stream_done got done=%b busy=%b en=%b mask=%h rdy=%b", done, busy, mem_en, rows_loaded, wr_ready);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || wr_ready !== 1'b1) begin
      bad++; $display("FAIL stream_rearm got done=%b rdy=%b exp 0 1", done, wr_ready);
    end
  endtask

  task automatic test_incomplete_start();
    bit seen;
    load_rows(8'h7F);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (start_err !== 1'b1 || busy !== 1'b0 || mem_en !== 1'b0 || rows_loaded !== 8'h7F || wr_ready !== 1'b1) begin
      bad++; $display("FAIL early_start got err=%b busy=%b en=%b mask=%h rdy=%b", start_err, busy, mem_en, rows_loaded, wr_ready);
    end
    @(negedge clk);
    total++;
    if (start_err !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL early_start_pulse got err=%b busy=%b exp 0 0", start_err, busy);
    end
    wr_valid = 1'b1; wr_row = 3'd7; set_row(7, 1'b0); start = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; start = 1'b0;
    total++;
    if (busy !== 1'b1 || mem_go !== 1'b1 || mem_en !== 1'b1 || start_err !== 1'b0) begin
      bad++; $display("FAIL same_cycle_start got busy=%b go=%b en=%b err=%b", busy, mem_go, mem_en, start_err);
    end
    total++;
    if (mem_wr !== 1'b1 || mem_row !== 3'd7 || mem_din[7] !== 32'sd63 || rows_loaded !== 8'hFF) begin
      bad++; $display("FAIL same_cycle_write got wr=%b row=%0d d7=%0d mask=%h", mem_wr, mem_row, mem_din[7], rows_loaded);
    end
    seen = 1'b0;
    for (int c = 0; c < 25 && !seen; c++) begin
      if (done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (!seen) begin bad++; $display("FAIL incomplete_done_timeout got=0 exp=1"); end
  endtask

  task automatic test_run_ignores();
    int en_cnt, done_at;
    bit seen;
    load_rows(8'hFF);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    en_cnt = 0; done_at = -1; seen = 1'b0;
    for (int c = 0; c < 25 && !seen; c++) begin
      total++;
      if (wr_ready !== 1'b0 || mem_wr !== 1'b0) begin
        bad++; $display("FAIL run_isolation cyc=%0d got rdy=%b wr=%b exp 0 0", c, wr_ready, mem_wr);
      end
      if (mem_en === 1'b1) en_cnt++;
      if (c == 0) begin wr_valid = 1'b1; wr_row = 3'd3; set_row(3, 1'b1); end
      if (c == 4) start = 1'b1;
      if (c == 5) begin
        start = 1'b0;
        total++;
        if (start_err !== 1'b1) begin bad++; $display("FAIL run_start_err got=%b exp=1", start_err); end
      end
      if (done === 1'b1) begin seen = 1'b1; done_at = c; wr_valid = 1'b0; end
      @(negedge clk);
    end
    total++;
    if (en_cnt != 15 || done_at != 15) begin
      bad++; $display("FAIL run_length got en=%0d done_at=%0d exp 15 15", en_cnt, done_at);
    end
    total++;
    if (rows_loaded !== 8'h00 || mem_wr !== 1'b0 || wr_ready !== 1'b1) begin
      bad++; $display("FAIL run_after got mask=%h wr=%b rdy=%b exp 00 0 1", rows_loaded, mem_wr, wr_ready);
    end
  endtask

  task automatic test_reset_abort();
    int en_cnt, done_at, done_cnt;
    bit seen;
    load_rows(8'hFF);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL abort_pre got busy=%b exp=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || mem_en !== 1'b0 || done !== 1'b0 || rows_loaded !== 8'h00 || wr_ready !== 1'b1) begin
      bad++; $display("FAIL abort_async got busy=%b en=%b done=%b mask=%h rdy=%b", busy, mem_en, done, rows_loaded, wr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
      @(negedge clk);
    end
    total++;
    if (done_cnt != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
    load_rows(8'hFF);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    en_cnt = 0; done_at = -1; seen = 1'b0;
    for (int c = 0; c < 25 && !seen; c++) begin
      if (mem_en === 1'b1) en_cnt++;
      if (done === 1'b1) begin seen = 1'b1; done_at = c; end
      @(negedge clk);
    end
    total++;
    if (en_cnt != 15 || done_at != 15) begin
      bad++; $display("FAIL abort_next_tile got en=%0d done_at=%0d exp 15 15", en_cnt, done_at);
    end
  endtask

  task automatic test_auto_start();
    int en_cnt, done_at;
    bit seen;
    load_rows(8'hFF);
    total++;
    if (rows_loaded !== 8'hFF || busy !== 1'b0) begin
      bad++; $display("FAIL auto_pre got mask=%h busy=%b exp ff 0", rows_loaded, busy);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || mem_go !== 1'b1) begin
      bad++; $display("FAIL auto_enter got busy=%b go=%b exp 1 1", busy, mem_go);
    end
    en_cnt = 0; done_at = -1; seen = 1'b0;
    for (int c = 0; c < 25 && !seen; c++) begin
      if (mem_en === 1'b1) en_cnt++;
      if (done === 1'b1) begin seen = 1'b1; done_at = c; end
      @(negedge clk);
    end
    total++;
    if (en_cnt != 15 || done_at != 15) begin
      bad++; $display("FAIL auto_length got en=%0d done_at=%0d exp 15 15", en_cnt, done_at);
    end
  endtask

  initial begin
    test_reset();
`ifdef MEMA_AUTO_START_EN
    test_auto_start();
`else
    test_load_rows();
    test_stream();
    test_incomplete_start();
    test_run_ignores();
    test_reset_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
